// File: rtl/rf_pkg.sv
// Shared constants and types for the general-purpose register file.
package rf_pkg;
  localparam int unsigned RF_ADDR_W       = 5;
  localparam int unsigned RF_ZERO_IDX     = 0;
  localparam int unsigned RF_DEF_WORDSIZE = 64;
  localparam int unsigned RF_DEF_SIZE     = 32;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
endpackage

// File: rtl/rf_word_reg.sv
// One register-file word: async active-low clear, synchronous load enable.
module rf_word_reg #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/register_file.sv
// Two combinational read ports, one synchronous write port; index 0 reads as zero.
module register_file
  import rf_pkg::*;
#(
  parameter int unsigned WORDSIZE = RF_DEF_WORDSIZE,
  parameter int unsigned SIZE     = RF_DEF_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                write_en,
  input  rf_addr_t            write_addr,
  input  logic [WORDSIZE-1:0] write_data,
  input  rf_addr_t            addr_a,
  output logic [WORDSIZE-1:0] data_a,
  input  rf_addr_t            addr_b,
  output logic [WORDSIZE-1:0] data_b
);
  logic [SIZE-1:0][WORDSIZE-1:0] w_regs;

  assign w_regs[RF_ZERO_IDX] = '0;

  // Decoder is distributed per word; index 0 gets no flops at all.
  for (genvar g = 1; g < SIZE; g++) begin : g_word
    logic w_load;
    assign w_load = write_en && (write_addr == rf_addr_t'(g));

    rf_word_reg #(
      .W (WORDSIZE)
    ) u_word (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_d    (write_data),
      .o_q    (w_regs[g])
    );
  end

  // Indices with no matching word (>= SIZE) fall through to the zero default.
  always_comb begin
    data_a = '0;
    data_b = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (addr_a == rf_addr_t'(i)) data_a = w_regs[i];
      if (addr_b == rf_addr_t'(i)) data_b = w_regs[i];
    end
  end
endmodule

// File: tb/tb_register_file.sv
// Scoreboard-driven bench for register_file.
module tb_register_file;
  typedef struct {
    logic [4:0]  aa;
    logic [4:0]  ab;
    logic [63:0] ea;
    logic [63:0] eb;
    string       name;
  } sb_entry_t;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [63:0] write_data;
  logic [4:0]  addr_a;
  logic [63:0] data_a;
  logic [4:0]  addr_b;
  logic [63:0] data_b;

  logic [63:0] mdl [32];
  sb_entry_t   sb [$];
  int          n_cmp;
  int          n_err;

  register_file #(
    .WORDSIZE (64),
    .SIZE     (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .addr_a     (addr_a),
    .data_a     (data_a),
    .addr_b     (addr_b),
    .data_b     (data_b)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic push(input logic [4:0] a, input logic [4:0] b, input string name);
    sb_entry_t e;
    e.aa = a; e.ab = b; e.ea = mdl[a]; e.eb = mdl[b]; e.name = name;
    sb.push_back(e);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d, input logic en);
    @(negedge clk);
    write_en = en; write_addr = a; write_data = d;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    if (en && a != 5'd0) mdl[a] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  task automatic test_reset();
    sb_entry_t e;
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    clear_model();
    for (int i = 0; i < 32; i++) push(5'(i), 5'(31 - i), "reset");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_a = e.aa; addr_b = e.ab;
      #1;
      n_cmp += 2;
      if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
      if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
    end
    rst_n = 1'b1;
    clk_en = 1'b1;
  endtask

  task automatic test_write_read();
    sb_entry_t e;
    do_write(5'd13, 64'hDEAD_BEEF_0123_4567, 1'b1);
    do_write(5'd6,  64'h0000_0000_0000_00A5, 1'b1);
    push(5'd13, 5'd6, "write_read");
    push(5'd6, 5'd13, "write_read_swap");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_a = e.aa; addr_b = e.ab;
      #1;
      n_cmp += 2;
      if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
      if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
    end
  endtask

  task automatic test_write_enable();
    sb_entry_t e;
    for (int i = 0; i < 4; i++) do_write(5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    push(5'd1, 5'd1, "we_gating");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_a = e.aa; addr_b = e.ab;
      #1;
      n_cmp += 2;
      if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
      if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
    end
  endtask

  task automatic test_zero_reg();
    sb_entry_t e;
    do_write(5'd0, 64'h1234, 1'b1);
    push(5'd0, 5'd0, "zero_reg");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_a = e.aa; addr_b = e.ab;
      #1;
      n_cmp += 2;
      if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
      if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
    end
  endtask

  task automatic test_same_cycle();
    sb_entry_t e;
    do_write(5'd5, 64'd7, 1'b1);
    @(negedge clk);
    write_en = 1'b1; write_addr = 5'd5; write_data = 64'd9;
    push(5'd5, 5'd5, "pre_edge_old");
    e = sb.pop_front();
    addr_a = e.aa; addr_b = e.ab;
    #1;
    n_cmp += 2;
    if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
    if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
    @(posedge clk);
    #1;
    write_en = 1'b0;
    mdl[5] = 64'd9;
    push(5'd5, 5'd5, "post_edge_new");
    e = sb.pop_front();
    addr_a = e.aa; addr_b = e.ab;
    #1;
    n_cmp += 2;
    if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
    if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
  endtask

  task automatic test_reset_activity();
    sb_entry_t e;
    do_write(5'd31, 64'h55, 1'b1);
    push(5'd31, 5'd13, "pre_reset");
    e = sb.pop_front();
    addr_a = e.aa; addr_b = e.ab;
    #1;
    n_cmp += 2;
    if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
    if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
    // Reset lands mid-write: the pending r7 write must be lost.
    @(negedge clk);
    write_en = 1'b1; write_addr = 5'd7; write_data = 64'hABCD;
    #1;
    rst_n = 1'b0;
    clear_model();
    push(5'd31, 5'd13, "async_reset");
    e = sb.pop_front();
    addr_a = e.aa; addr_b = e.ab;
    #1;
    n_cmp += 2;
    if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
    if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
    @(posedge clk);
    #2;
    write_en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push(5'd31, 5'd7, "after_release");
    push(5'd5, 5'd6, "after_release");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_a = e.aa; addr_b = e.ab;
      #1;
      n_cmp += 2;
      if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
      if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
    end
    do_write(5'd31, 64'h66, 1'b1);
    push(5'd31, 5'd31, "rewrite");
    e = sb.pop_front();
    addr_a = e.aa; addr_b = e.ab;
    #1;
    n_cmp += 2;
    if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
    if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
  endtask

  task automatic test_random();
    sb_entry_t e;
    for (int i = 0; i < 60; i++)
      do_write(5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 32; i++) push(5'(i), 5'($urandom_range(0, 31)), "random");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_a = e.aa; addr_b = e.ab;
      #1;
      n_cmp += 2;
      if (data_a !== e.ea) begin n_err++; $display("FAIL %s A[%0d]: got %h want %h", e.name, e.aa, data_a, e.ea); end
      if (data_b !== e.eb) begin n_err++; $display("FAIL %s B[%0d]: got %h want %h", e.name, e.ab, data_b, e.eb); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    clk_en = 1'b0;
    rst_n = 1'b1;
    write_en = 1'b0; write_addr = '0; write_data = '0;
    addr_a = '0; addr_b = '0;
    clear_model();
    test_reset();
    test_write_read();
    test_write_enable();
    test_zero_reg();
    test_same_cycle();
    test_reset_activity();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
